// File: rtl/port_a_mode1_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : port_a_mode1_ctrl
// Brief    : 8255 Mode 1 strobed-handshake sequencer for Port A (in/out).
// Revision : 1.0
// ============================================================================
module port_a_mode1_ctrl #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              dir_in,
  input  logic              inte,
  input  logic              stb_n,
  input  logic              ack_n,
  input  logic              rd_pulse,
  input  logic              wr_pulse,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] pa_in,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [DATA_W-1:0] pa_out,
  output logic              pa_oe,
  output logic              ibf,
  output logic              obf_n,
  output logic              intr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FULL  = 2'd1,
    OUT_FULL = 2'd2,
    OUT_ACK  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic stb_prev_q, stb_prev_d, ack_prev_q, ack_prev_d;
  logic stb_fall_q, stb_fall_d, stb_rise_q, stb_rise_d;
  logic ack_fall_q, ack_fall_d, ack_rise_q, ack_rise_d;
  logic dir_prev_q, dir_prev_d;
  logic [DATA_W-1:0] in_latch_q, in_latch_d;
  logic [DATA_W-1:0] out_latch_q, out_latch_d;
  logic ibf_q, ibf_d, obf_n_q, obf_n_d, intr_q, intr_d;

  always_comb begin
    stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0], stb_n};
    ack_sync_d  = {ack_sync_q[SYNC_STAGES-2:0], ack_n};
    stb_prev_d  = stb_sync_q[SYNC_STAGES-1];
    ack_prev_d  = ack_sync_q[SYNC_STAGES-1];
    // Edge pulses are registered so each lasts exactly one cycle after the synchroniser.
    stb_fall_d  = stb_prev_q & ~stb_sync_q[SYNC_STAGES-1];
    stb_rise_d  = ~stb_prev_q & stb_sync_q[SYNC_STAGES-1];
    ack_fall_d  = ack_prev_q & ~ack_sync_q[SYNC_STAGES-1];
    ack_rise_d  = ~ack_prev_q & ack_sync_q[SYNC_STAGES-1];
    dir_prev_d  = dir_in;

    state_d     = state_q;
    in_latch_d  = in_latch_q;
    out_latch_d = out_latch_q;
    ibf_d       = ibf_q;
    obf_n_d     = obf_n_q;
    intr_d      = intr_q;

    if (!enable || (dir_in != dir_prev_q)) begin
      state_d = IDLE;
      ibf_d   = 1'b0;
      obf_n_d = 1'b1;
      intr_d  = 1'b0;
    end else if (dir_in) begin
      case (state_q)
        IDLE: begin
          if (stb_fall_q) begin
            in_latch_d = pa_in;
            ibf_d      = 1'b1;
            state_d    = IN_FULL;
          end
        end
        IN_FULL: begin
          if (rd_pulse) begin
            ibf_d   = 1'b0;
            intr_d  = 1'b0;
            state_d = IDLE;
          end else if (stb_rise_q) begin
            intr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (wr_pulse) begin
        out_latch_d = cpu_wdata;
        obf_n_d     = 1'b0;
        intr_d      = 1'b0;
        state_d     = OUT_FULL;
      end else begin
        case (state_q)
          OUT_FULL: begin
            if (ack_fall_q) begin
              obf_n_d = 1'b1;
              state_d = OUT_ACK;
            end
          end
          OUT_ACK: begin
            if (ack_rise_q) begin
              intr_d  = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // A masked set condition is dropped rather than held for later.
    if (!inte) intr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      stb_sync_q  <= '1;
      ack_sync_q  <= '1;
      stb_prev_q  <= 1'b1;
      ack_prev_q  <= 1'b1;
      stb_fall_q  <= 1'b0;
      stb_rise_q  <= 1'b0;
      ack_fall_q  <= 1'b0;
      ack_rise_q  <= 1'b0;
      dir_prev_q  <= 1'b0;
      in_latch_q  <= '0;
      out_latch_q <= '0;
      ibf_q       <= 1'b0;
      obf_n_q     <= 1'b1;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stb_sync_q  <= stb_sync_d;
      ack_sync_q  <= ack_sync_d;
      stb_prev_q  <= stb_prev_d;
      ack_prev_q  <= ack_prev_d;
      stb_fall_q  <= stb_fall_d;
      stb_rise_q  <= stb_rise_d;
      ack_fall_q  <= ack_fall_d;
      ack_rise_q  <= ack_rise_d;
      dir_prev_q  <= dir_prev_d;
      in_latch_q  <= in_latch_d;
      out_latch_q <= out_latch_d;
      ibf_q       <= ibf_d;
      obf_n_q     <= obf_n_d;
      intr_q      <= intr_d;
    end
  end

  assign cpu_rdata = in_latch_q;
  assign pa_out    = out_latch_q;
  assign ibf       = ibf_q;
  assign obf_n     = obf_n_q;
  assign intr      = intr_q & inte;
  assign pa_oe     = enable & ~dir_in & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_port_a_mode1_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_port_a_mode1_ctrl
// Brief    : Self-checking bench for port_a_mode1_ctrl with a data scoreboard.
// Revision : 1.0
// ============================================================================
module tb_port_a_mode1_ctrl;
  localparam int DATA_W = 8;
  localparam int SYNC_STAGES = 2;

  logic clk = 1'b0;
  logic reset, enable, dir_in, inte, stb_n, ack_n, rd_pulse, wr_pulse;
  logic [DATA_W-1:0] cpu_wdata, pa_in, cpu_rdata, pa_out;
  logic pa_oe, ibf, obf_n, intr;

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  port_a_mode1_ctrl #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir_in(dir_in), .inte(inte),
    .stb_n(stb_n), .ack_n(ack_n), .rd_pulse(rd_pulse), .wr_pulse(wr_pulse),
    .cpu_wdata(cpu_wdata), .pa_in(pa_in), .cpu_rdata(cpu_rdata), .pa_out(pa_out),
    .pa_oe(pa_oe), .ibf(ibf), .obf_n(obf_n), .intr(intr)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; dir_in = 1'b0; inte = 1'b0;
    stb_n = 1'b1; ack_n = 1'b1; rd_pulse = 1'b0; wr_pulse = 1'b0;
    cpu_wdata = '0; pa_in = '0;
    step(2);
    total++; if (ibf !== 1'b0)   begin bad++; $display("FAIL reset_ibf got=%b exp=0", ibf); end
    total++; if (obf_n !== 1'b1) begin bad++; $display("FAIL reset_obf_n got=%b exp=1", obf_n); end
    total++; if (intr !== 1'b0)  begin bad++; $display("FAIL reset_intr got=%b exp=0", intr); end
    total++; if (pa_oe !== 1'b0) begin bad++; $display("FAIL reset_pa_oe got=%b exp=0", pa_oe); end
    total++; if (pa_out !== 8'h00 || cpu_rdata !== 8'h00) begin
      bad++; $display("FAIL reset_latches got=%h/%h exp=00/00", pa_out, cpu_rdata);
    end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_input;
    logic [DATA_W-1:0] e;
    dir_in = 1'b1; inte = 1'b1;
    step(2);
    pa_in = 8'hA5; stb_n = 1'b0; exp_q.push_back(8'hA5);
    step(3);
    total++; if (ibf !== 1'b0) begin bad++; $display("FAIL in_ibf_early got=%b exp=0", ibf); end
    step(1);
    total++; if (ibf !== 1'b1) begin bad++; $display("FAIL in_ibf_set got=%b exp=1", ibf); end
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL in_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (cpu_rdata !== e) begin bad++; $display("FAIL in_rdata got=%h exp=%h", cpu_rdata, e); end
    end
    step(2);
    stb_n = 1'b1; pa_in = 8'h00;
    step(3);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL in_intr_early got=%b exp=0", intr); end
    step(1);
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL in_intr_set got=%b exp=1", intr); end
    rd_pulse = 1'b1; step(1); rd_pulse = 1'b0;
    total++; if (ibf !== 1'b0 || intr !== 1'b0) begin
      bad++; $display("FAIL in_read_clear got=ibf%b/intr%b exp=0/0", ibf, intr);
    end
  endtask

  task automatic test_overrun;
    logic [DATA_W-1:0] e;
    pa_in = 8'hA5; stb_n = 1'b0; exp_q.push_back(8'hA5);
    step(6); stb_n = 1'b1; step(6);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL ovr_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (cpu_rdata !== e || ibf !== 1'b1) begin
        bad++; $display("FAIL ovr_first got=%h/ibf%b exp=%h/ibf1", cpu_rdata, ibf, e);
      end
    end
    pa_in = 8'h3C; stb_n = 1'b0; step(6); stb_n = 1'b1; step(6);
    total++; if (cpu_rdata !== 8'hA5 || ibf !== 1'b1) begin
      bad++; $display("FAIL ovr_no_relatch got=%h/ibf%b exp=a5/ibf1", cpu_rdata, ibf);
    end
    rd_pulse = 1'b1; step(1); rd_pulse = 1'b0;
    rd_pulse = 1'b1; step(1); rd_pulse = 1'b0;
    total++; if (cpu_rdata !== 8'hA5 || ibf !== 1'b0) begin
      bad++; $display("FAIL ovr_idle_read got=%h/ibf%b exp=a5/ibf0", cpu_rdata, ibf);
    end
  endtask

  task automatic test_output;
    logic [DATA_W-1:0] e;
    dir_in = 1'b0; inte = 1'b1;
    step(2);
    cpu_wdata = 8'h5A; wr_pulse = 1'b1; exp_q.push_back(8'h5A);
    step(1); wr_pulse = 1'b0;
    total++; if (obf_n !== 1'b0 || pa_oe !== 1'b1) begin
      bad++; $display("FAIL out_wr got=obf_n%b/oe%b exp=0/1", obf_n, pa_oe);
    end
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL out_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (pa_out !== e) begin bad++; $display("FAIL out_data got=%h exp=%h", pa_out, e); end
    end
    ack_n = 1'b0; step(3);
    total++; if (obf_n !== 1'b0) begin bad++; $display("FAIL out_obf_early got=%b exp=0", obf_n); end
    step(1);
    total++; if (obf_n !== 1'b1) begin bad++; $display("FAIL out_obf_ack got=%b exp=1", obf_n); end
    step(2); ack_n = 1'b1; step(3);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL out_intr_early got=%b exp=0", intr); end
    step(1);
    total++; if (intr !== 1'b1) begin bad++; $display("FAIL out_intr_set got=%b exp=1", intr); end
    cpu_wdata = 8'hC3; wr_pulse = 1'b1; exp_q.push_back(8'hC3);
    step(1); wr_pulse = 1'b0;
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL out2_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (pa_out !== e || intr !== 1'b0 || obf_n !== 1'b0) begin
        bad++; $display("FAIL out_rewrite got=%h/intr%b/obf_n%b exp=%h/0/0", pa_out, intr, obf_n, e);
      end
    end
  endtask

  task automatic test_output_no_inte;
    inte = 1'b0;
    cpu_wdata = 8'h96; wr_pulse = 1'b1; step(1); wr_pulse = 1'b0;
    ack_n = 1'b0; step(6); ack_n = 1'b1; step(6);
    total++; if (intr !== 1'b0 || obf_n !== 1'b1) begin
      bad++; $display("FAIL noint_masked got=intr%b/obf_n%b exp=0/1", intr, obf_n);
    end
    inte = 1'b1; step(1);
    total++; if (intr !== 1'b0) begin bad++; $display("FAIL noint_late_inte got=%b exp=0", intr); end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] e;
    cpu_wdata = 8'h11; wr_pulse = 1'b1; exp_q.push_back(8'h11);
    step(1);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (pa_out !== e) begin bad++; $display("FAIL b2b_first got=%h exp=%h", pa_out, e); end
    end
    cpu_wdata = 8'h22; exp_q.push_back(8'h22);
    step(1); wr_pulse = 1'b0;
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb_empty2 got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (pa_out !== e || obf_n !== 1'b0) begin
        bad++; $display("FAIL b2b_second got=%h/obf_n%b exp=%h/0", pa_out, obf_n, e);
      end
    end
    // Write lands on the cycle the ack fall is presented: the ack is discarded.
    ack_n = 1'b0; step(3);
    cpu_wdata = 8'h44; wr_pulse = 1'b1; exp_q.push_back(8'h44);
    step(1); wr_pulse = 1'b0;
    step(3);
    total++; if (obf_n !== 1'b0) begin bad++; $display("FAIL b2b_wr_wins got=%b exp=0", obf_n); end
    ack_n = 1'b1; step(6);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL b2b_sb_empty3 got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (pa_out !== e || obf_n !== 1'b0 || intr !== 1'b0) begin
        bad++; $display("FAIL b2b_after_race got=%h/obf_n%b/intr%b exp=%h/0/0", pa_out, obf_n, intr, e);
      end
    end
  endtask

  task automatic test_race_and_dir;
    logic [DATA_W-1:0] e;
    dir_in = 1'b1; inte = 1'b1;
    step(2);
    pa_in = 8'h77; stb_n = 1'b0; exp_q.push_back(8'h77);
    step(6);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL race_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (cpu_rdata !== e || ibf !== 1'b1) begin
        bad++; $display("FAIL race_fill got=%h/ibf%b exp=%h/1", cpu_rdata, ibf, e);
      end
    end
    stb_n = 1'b1; step(3);
    rd_pulse = 1'b1; step(1); rd_pulse = 1'b0;
    step(2);
    total++; if (ibf !== 1'b0 || intr !== 1'b0) begin
      bad++; $display("FAIL race_read_wins got=ibf%b/intr%b exp=0/0", ibf, intr);
    end
    pa_in = 8'h88; stb_n = 1'b0; step(6); stb_n = 1'b1; step(6);
    total++; if (intr !== 1'b1 || cpu_rdata !== 8'h88) begin
      bad++; $display("FAIL dir_prefill got=intr%b/%h exp=1/88", intr, cpu_rdata);
    end
    dir_in = 1'b0; step(1);
    total++; if (ibf !== 1'b0 || intr !== 1'b0) begin
      bad++; $display("FAIL dir_flip got=ibf%b/intr%b exp=0/0", ibf, intr);
    end
    dir_in = 1'b1; step(2);
    total++; if (cpu_rdata !== 8'h88) begin bad++; $display("FAIL dir_latch_kept got=%h exp=88", cpu_rdata); end
    pa_in = 8'h99; stb_n = 1'b0; exp_q.push_back(8'h99); step(6);
    total++;
    if (exp_q.size() == 0) begin bad++; $display("FAIL dir_sb_empty got=none exp=entry"); end
    else begin
      e = exp_q.pop_front();
      if (cpu_rdata !== e || ibf !== 1'b1) begin
        bad++; $display("FAIL dir_idle_refill got=%h/ibf%b exp=%h/1", cpu_rdata, ibf, e);
      end
    end
    stb_n = 1'b1; step(6);
    rd_pulse = 1'b1; step(1); rd_pulse = 1'b0;
  endtask

  task automatic test_reset_mid_out;
    dir_in = 1'b0; inte = 1'b1; step(2);
    cpu_wdata = 8'h5A; wr_pulse = 1'b1; step(1); wr_pulse = 1'b0;
    total++; if (obf_n !== 1'b0) begin bad++; $display("FAIL rst_pre got=%b exp=0", obf_n); end
    #2 reset = 1'b1;
    #1;
    total++; if (obf_n !== 1'b1 || intr !== 1'b0 || pa_oe !== 1'b0 || pa_out !== 8'h00) begin
      bad++; $display("FAIL rst_async got=obf_n%b/intr%b/oe%b/%h exp=1/0/0/00", obf_n, intr, pa_oe, pa_out);
    end
    step(1); reset = 1'b0; step(2);
    total++; if (obf_n !== 1'b1 || pa_oe !== 1'b1 || pa_out !== 8'h00) begin
      bad++; $display("FAIL rst_release got=obf_n%b/oe%b/%h exp=1/1/00", obf_n, pa_oe, pa_out);
    end
  endtask

  initial begin
    test_reset();
    test_input();
    test_overrun();
    test_output();
    test_output_no_inte();
    test_back_to_back();
    test_race_and_dir();
    test_reset_mid_out();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
